// File: rtl/periph_timer_responder.sv
// Data-bus responder with programmable wait states and a 64-bit timer/compare unit.
// Optional TIMER_PRESCALER_EN adds a 16-bit PRESCALE register at offset 0x20.
//   state   | meaning
//   ST_IDLE | waiting for a request in the window
//   ST_WAIT | request latched, counting wait states
//   ST_RESP | d_ready pulse, store commits
module periph_timer_responder #(
  parameter logic [63:0] BASE_ADDR = 64'h2000_0000,
  parameter int          WIN_BITS  = 8,
  parameter int          LATENCY   = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  input  logic [1:0]  d_store_type,
  input  logic        d_valid,
  output logic        d_ready,
  output logic [63:0] d_rdata,
  output logic        irq
);

  localparam int WW = WIN_BITS - 3;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t          state, state_nxt;
  logic            sel, accept;
  logic [3:0]      wait_cnt;
  logic [WW-1:0]   req_word;
  logic [63:0]     req_wdata;
  logic            req_store;

  logic [2:0]      ctrl;
  logic [63:0]     compare, count;
  logic            match;
  logic            tick, hit;
  logic            wr, wr_ctrl, wr_cmp, wr_cnt, wr_stat;
  logic [63:0]     psc_rd, rd_mux;
  logic            unused_addr;

  assign unused_addr = ^d_addr[2:0];
  assign sel = d_valid & (d_addr[63:WIN_BITS] == BASE_ADDR[63:WIN_BITS]);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    d_ready   = 1'b0;
    case (state)
      ST_IDLE: if (sel) begin
        accept    = 1'b1;
        state_nxt = (LATENCY == 0) ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: if (wait_cnt == 4'd0) state_nxt = ST_RESP;
      ST_RESP: begin
        d_ready   = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request is frozen at accept so the core may change or drop the bus afterwards
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt  <= 4'd0;
      req_word  <= '0;
      req_wdata <= 64'd0;
      req_store <= 1'b0;
    end else if (accept) begin
      wait_cnt  <= 4'(LATENCY - 1);
      req_word  <= d_addr[WIN_BITS-1:3];
      req_wdata <= d_wdata;
      req_store <= |d_store_type;
    end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  assign wr      = d_ready & req_store;
  assign wr_ctrl = wr & (req_word == WW'(0));
  assign wr_cmp  = wr & (req_word == WW'(1));
  assign wr_cnt  = wr & (req_word == WW'(2));
  assign wr_stat = wr & (req_word == WW'(3));
  assign hit     = ctrl[0] & (count == compare);

`ifdef TIMER_PRESCALER_EN
  logic        wr_psc;
  logic [15:0] prescale, psc_cnt;

  assign wr_psc = wr & (req_word == WW'(4));
  assign tick   = ctrl[0] & (psc_cnt == prescale);
  assign psc_rd = {48'd0, prescale};

  // Restart the prescale phase whenever the timer is enabled or the divisor changes
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prescale <= 16'd0;
      psc_cnt  <= 16'd0;
    end else if (wr_psc) begin
      prescale <= req_wdata[15:0];
      psc_cnt  <= 16'd0;
    end else if (wr_ctrl & req_wdata[0] & ~ctrl[0]) begin
      psc_cnt <= 16'd0;
    end else if (ctrl[0]) begin
      psc_cnt <= tick ? 16'd0 : psc_cnt + 16'd1;
    end
  end
`else
  assign tick   = ctrl[0];
  assign psc_rd = 64'd0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ctrl    <= 3'd0;
      compare <= '1;
      count   <= 64'd0;
      match   <= 1'b0;
      irq     <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl <= req_wdata[2:0];
      if (wr_cmp)  compare <= req_wdata;
      if (wr_cnt)      count <= req_wdata;
      else if (tick)   count <= (ctrl[2] & hit) ? 64'd0 : count + 64'd1;
      if (hit)                        match <= 1'b1;
      else if (wr_stat & req_wdata[0]) match <= 1'b0;
      irq <= match & ctrl[1];
    end
  end

  always_comb begin
    rd_mux = 64'd0;
    case (req_word)
      WW'(0):  rd_mux = {61'd0, ctrl};
      WW'(1):  rd_mux = compare;
      WW'(2):  rd_mux = count;
      WW'(3):  rd_mux = {63'd0, match};
      WW'(4):  rd_mux = psc_rd;
      default: rd_mux = 64'd0;
    endcase
  end

  assign d_rdata = (d_ready & ~req_store) ? rd_mux : 64'd0;

endmodule

// File: tb/tb_periph_timer_responder.sv
// Self-checking bench for periph_timer_responder: register vector table plus timer,
// back-to-back, dropped-valid and reset-abort sequences.
module tb_periph_timer_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] d_addr = 64'd0;
  logic [63:0] d_wdata = 64'd0;
  logic [1:0]  d_store_type = 2'd0;
  logic        d_valid = 1'b0;
  logic        d_ready;
  logic [63:0] d_rdata;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  localparam logic [63:0] A_CTRL = 64'h2000_0000;
  localparam logic [63:0] A_CMP  = 64'h2000_0008;
  localparam logic [63:0] A_CNT  = 64'h2000_0010;
  localparam logic [63:0] A_STAT = 64'h2000_0018;
  localparam logic [63:0] A_PSC  = 64'h2000_0020;
  localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

  periph_timer_responder #(
    .BASE_ADDR(64'h2000_0000), .WIN_BITS(8), .LATENCY(1)
  ) dut (
    .clock(clock), .reset(reset), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_store_type(d_store_type), .d_valid(d_valid), .d_ready(d_ready),
    .d_rdata(d_rdata), .irq(irq)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [1:0]  st;
    logic        exp_ready;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic [63:0] addr, input logic [63:0] wdata, input logic [1:0] st,
                      input int budget, output logic got, output logic [63:0] rd, output int n);
    @(negedge clock);
    d_addr = addr; d_wdata = wdata; d_store_type = st; d_valid = 1'b1;
    got = 1'b0; rd = 64'd0; n = 0;
    for (int i = 1; i <= budget && !got; i++) begin
      @(negedge clock);
      if (d_ready) begin
        got = 1'b1; rd = d_rdata; n = i;
      end
    end
    d_valid = 1'b0; d_store_type = 2'd0;
  endtask

  task automatic wr(input string name, input logic [63:0] addr, input logic [63:0] data);
    logic got; logic [63:0] rd; int n;
    xfer(addr, data, 2'd3, 20, got, rd, n);
    chk({name, "_ready"}, {63'd0, got}, 64'd1);
  endtask

  task automatic rdc(input string name, input logic [63:0] addr, input logic [63:0] exp);
    logic got; logic [63:0] rd; int n;
    xfer(addr, 64'd0, 2'd0, 20, got, rd, n);
    chk({name, "_ready"}, {63'd0, got}, 64'd1);
    chk(name, rd, exp);
  endtask

  task automatic rd_at(input logic [63:0] addr, output logic [63:0] rd, output int at);
    logic got; int n;
    xfer(addr, 64'd0, 2'd0, 20, got, rd, n);
    chk("rd_at_ready", {63'd0, got}, 64'd1);
    at = cyc;
  endtask

  initial begin
    logic got; logic [63:0] rd; int n, x, at, rise, pulses;
    logic seen;

    vecs[0]  = '{A_CMP,              64'd0,                  2'd0, 1'b1, ONES};
    vecs[1]  = '{A_CNT,              64'd0,                  2'd0, 1'b1, 64'd0};
    vecs[2]  = '{A_CTRL,             64'd0,                  2'd0, 1'b1, 64'd0};
    vecs[3]  = '{A_STAT,             64'd0,                  2'd0, 1'b1, 64'd0};
    vecs[4]  = '{A_CMP,              64'h1122_3344_5566_7788, 2'd1, 1'b1, 64'd0};
    vecs[5]  = '{64'h2000_000C,      64'd0,                  2'd0, 1'b1, 64'h1122_3344_5566_7788};
    vecs[6]  = '{A_CNT,              64'hDEAD_BEEF_0000_0042, 2'd2, 1'b1, 64'd0};
    vecs[7]  = '{A_CNT,              64'd0,                  2'd0, 1'b1, 64'hDEAD_BEEF_0000_0042};
    vecs[8]  = '{A_CTRL,             64'hFFFF_FFF6,          2'd3, 1'b1, 64'd0};
    vecs[9]  = '{A_CTRL,             64'd0,                  2'd0, 1'b1, 64'd6};
    vecs[10] = '{A_CTRL,             64'd0,                  2'd1, 1'b1, 64'd0};
    vecs[11] = '{64'h2000_0028,      64'h55,                 2'd1, 1'b1, 64'd0};
    vecs[12] = '{64'h2000_0028,      64'd0,                  2'd0, 1'b1, 64'd0};
    vecs[13] = '{64'h2000_00F8,      64'd0,                  2'd0, 1'b1, 64'd0};
    vecs[14] = '{64'h3000_0000,      64'd0,                  2'd0, 1'b0, 64'd0};
    vecs[15] = '{64'h2000_0100,      64'h99,                 2'd1, 1'b0, 64'd0};
    vecs[16] = '{A_PSC,              64'd0,                  2'd0, 1'b1, 64'd0};

    repeat (3) @(negedge clock);
    chk("rst_d_ready", {63'd0, d_ready}, 64'd0);
    chk("rst_d_rdata", d_rdata, 64'd0);
    chk("rst_irq", {63'd0, irq}, 64'd0);
    reset = 1'b1;

    // first load: d_ready two cycles after accept
    xfer(A_CNT, 64'd0, 2'd0, 20, got, rd, n);
    chk("lat_cycles", 64'(n), 64'd2);
    chk("lat_rdata", rd, 64'd0);

    for (int i = 0; i < 17; i++) begin
      xfer(vecs[i].addr, vecs[i].wdata, vecs[i].st, vecs[i].exp_ready ? 20 : 8, got, rd, n);
      chk($sformatf("vec%0d_ready", i), {63'd0, got}, {63'd0, vecs[i].exp_ready});
      if (got && vecs[i].st == 2'd0) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
    end

    // compare match and irq timing
    wr("m_cnt", A_CNT, 64'd0);
    wr("m_cmp", A_CMP, 64'd5);
    wr("m_ctrl", A_CTRL, 64'd3);
    rise = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (irq && rise == 0) rise = k;
    end
    chk("irq_rise_cycle", 64'(rise), 64'd8);
    rdc("m_status", A_STAT, 64'd1);
    wr("m_w1c", A_STAT, 64'd1);
    @(negedge clock);
    chk("irq_lag", {63'd0, irq}, 64'd1);
    @(negedge clock);
    chk("irq_cleared", {63'd0, irq}, 64'd0);
    rdc("m_status_clr", A_STAT, 64'd0);
    wr("m_off", A_CTRL, 64'd0);

    // auto_clear: count runs 0,1,2,3,0,...
    wr("ac_cnt", A_CNT, 64'd0);
    wr("ac_cmp", A_CMP, 64'd3);
    wr("ac_ctrl", A_CTRL, 64'd7);
    x = cyc;
    for (int r = 0; r < 3; r++) begin
      rd_at(A_CNT, rd, at);
      chk($sformatf("ac_count%0d", r), rd, 64'((at - x - 1) % 4));
    end
    chk("ac_irq", {63'd0, irq}, 64'd1);
    wr("ac_w1c", A_STAT, 64'd1);
    repeat (8) @(negedge clock);
    rdc("ac_rematch", A_STAT, 64'd1);
    wr("ac_off", A_CTRL, 64'd0);
    wr("ac_w1c2", A_STAT, 64'd1);
    rdc("ac_status_clr", A_STAT, 64'd0);

    // wrap from all-ones to zero without a match
    wr("w_cmp", A_CMP, 64'd5);
    wr("w_cnt", A_CNT, ONES);
    wr("w_ctrl", A_CTRL, 64'd1);
    x = cyc;
    rdc("w_status", A_STAT, 64'd0);
    rd_at(A_CNT, rd, at);
    chk("w_count", rd, ONES + 64'(at - x - 1));
    wr("w_off", A_CTRL, 64'd0);

    // back-to-back stores with d_valid held
    @(negedge clock);
    d_addr = A_CMP; d_wdata = 64'hAAAA_0000_0000_0001; d_store_type = 2'd1; d_valid = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40 && pulses < 2; i++) begin
      @(negedge clock);
      if (d_ready) begin
        pulses++;
        d_addr = A_CNT; d_wdata = 64'hBBBB_0000_0000_0002;
      end
    end
    d_valid = 1'b0; d_store_type = 2'd0;
    chk("b2b_pulses", 64'(pulses), 64'd2);
    rdc("b2b_cmp", A_CMP, 64'hAAAA_0000_0000_0001);
    rdc("b2b_cnt", A_CNT, 64'hBBBB_0000_0000_0002);

    // d_valid dropped after accept still completes the store
    @(negedge clock);
    d_addr = A_CMP; d_wdata = 64'hA5A5; d_store_type = 2'd2; d_valid = 1'b1;
    @(negedge clock);
    d_valid = 1'b0; d_store_type = 2'd0; d_addr = 64'h3000_0000;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clock);
      if (d_ready) seen = 1'b1;
    end
    chk("drop_ready", {63'd0, seen}, 64'd1);
    rdc("drop_cmp", A_CMP, 64'hA5A5);

    // reset in the WAIT state aborts the transaction
    @(negedge clock);
    d_addr = A_CMP; d_wdata = 64'h1234; d_store_type = 2'd1; d_valid = 1'b1;
    @(negedge clock);
    reset = 1'b0; d_valid = 1'b0; d_store_type = 2'd0;
    #1;
    chk("abort_ready_now", {63'd0, d_ready}, 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (d_ready) seen = 1'b1;
    end
    chk("abort_no_ready", {63'd0, seen}, 64'd0);
    rdc("abort_cmp", A_CMP, ONES);
    rdc("abort_cnt", A_CNT, 64'd0);

`ifdef TIMER_PRESCALER_EN
    wr("p_psc", A_PSC, 64'd3);
    rdc("p_psc_rd", A_PSC, 64'd3);
    wr("p_cnt", A_CNT, 64'd0);
    wr("p_ctrl", A_CTRL, 64'd1);
    x = cyc;
    for (int r = 0; r < 3; r++) begin
      rd_at(A_CNT, rd, at);
      chk($sformatf("p_count%0d", r), rd, 64'((at - x - 1) / 4));
    end
    wr("p_off", A_CTRL, 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
